// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Holds the FSM state encoding, the nibble width and the signed-overflow rule.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: like-signed operands producing an opposite-signed result.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_adder.sv
// Purely combinational 4-bit ripple-carry adder.
// Each generated stage is a 1-bit full-adder cell whose carry feeds the next stage.
module nibble_adder
    import nibble_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Cin,
    output logic [NIBBLE_W-1:0] Sum,
    output logic                Cout
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = Cin;

    for (genvar g = 0; g < NIBBLE_W; g++) begin : g_fa_cell
        assign Sum[g]   = A[g] ^ B[g] ^ w_c[g];
        assign w_c[g+1] = (A[g] & B[g]) | (w_c[g] & (A[g] ^ B[g]));
    end

    assign Cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a shared 4-bit adder.
// Operands and results move over valid/ready handshakes; all outputs are registered.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_result;
    logic                r_carry;
    logic                r_overflow;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [IDX_W-1:0]    r_idx;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum;
    logic                w_cout;
    logic                w_accept;
    logic                w_last;
    logic                w_release;

    // r_in_ready is high only in IDLE, so it doubles as the accept qualifier.
    assign w_accept  = in_valid && r_in_ready;
    assign w_last    = (r_state == BUSY) && (r_idx == LAST_IDX);
    assign w_release = r_out_valid && out_ready;

    assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

    nibble_adder u_nibble_adder (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .Cin  (r_carry),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = BUSY;
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = BUSY;
                end
            end
            DONE: begin
                if (w_release) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, nibble stepping, carry chain and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_result    <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_idx       <= {IDX_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            // out_valid registers one cycle into DONE, once the final nibble has settled.
            r_out_valid <= (r_state == DONE) && (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a        <= op_a;
                        r_b        <= sub ? ~op_b : op_b;
                        r_carry    <= sub;
                        r_idx      <= {IDX_W{1'b0}};
                        r_overflow <= 1'b0;
                    end
                end
                BUSY: begin
                    r_result[r_idx*NIBBLE_W +: NIBBLE_W] <= w_sum;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_idx      <= {IDX_W{1'b0}};
                        r_overflow <= signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_sum[NIBBLE_W-1]);
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry_out = r_carry;
    assign overflow  = r_overflow;

endmodule
